bbc_mem_arbiter: RTL and testbench

// - Shares the single-port ROM/RAM block RAMs between the BBC core external bus and the HPS

---
 rtl/bbc_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_bbc_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// bbc_mem_arbiter
//
// Shares the single-port ROM/RAM block RAMs between the BBC core external bus
// and the HPS ioctl loader. Core accesses always win; loader bytes are held in
// a small FIFO and written into memory during idle cycles.
//
// Ports
//   clk_sys         system clock
//   reset_n         asynchronous active-low reset
//   core_req        1-cycle pulse, core address/nWE/data valid
//   core_addr[18:0] core address, bit 18 = 1 RAM, 0 ROM
//   core_we_n       core write enable (active low)
//   core_din[7:0]   core write data
//   core_dout[7:0]  read data, held until the next core read completes
//   core_rdy        1-cycle pulse, core access finished
//   ioctl_download  loader active
//   ioctl_index     loader target index (ROM / RAM / ignored)
//   ioctl_wr        loader byte strobe
//   ioctl_addr      loader byte address
//   ioctl_dout      loader byte
//   ioctl_wait      loader must stall (FIFO nearly full)
//   mem_addr        registered memory address
//   mem_din         registered memory write data
//   mem_wren        registered single-cycle write strobe
//   mem_q           memory read data, valid one cycle after mem_addr
//   rom_wr_err      sticky flag: core attempted a ROM write
//
// Build option
//   BBC_MEM_ARB_WRITE_PROTECT_EN : when defined, core writes to the ROM
//   region are turned into read cycles and flag rom_wr_err. When undefined,
//   core ROM writes go through and rom_wr_err is tied low.
// ----------------------------------------------------------------------------
module bbc_mem_arbiter #(
  parameter int         LOAD_FIFO_DEPTH = 4,
  parameter logic [7:0] LOAD_IDX_ROM    = 8'd0,
  parameter logic [7:0] LOAD_IDX_RAM    = 8'd1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic [18:0] core_addr,
  input  logic        core_we_n,
  input  logic [7:0]  core_din,
  output logic [7:0]  core_dout,
  output logic        core_rdy,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [17:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_wren,
  input  logic [7:0]  mem_q,
  output logic        rom_wr_err
);

  localparam int PW = (LOAD_FIFO_DEPTH > 1) ? $clog2(LOAD_FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LOAD_FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_C  = CW'(LOAD_FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORE_A  = 2'd1,
    CORE_D  = 2'd2,
    LOAD_WR = 2'd3
  } state_t;

  state_t state;

  // --------------------------------------------------------------------------
  // Core request capture
  // --------------------------------------------------------------------------
  logic        pend_valid;
  logic [18:0] pend_addr;
  logic [7:0]  pend_din;
  logic        pend_wr;      // write that qualifies for a strobe (nWE edge)
  logic        last_we_n;    // core_we_n seen at the previous core_req

  logic        wr_edge;
  logic        req_valid;
  logic        take_core;
  logic        capture;
  logic [18:0] sel_addr;
  logic [7:0]  sel_din;
  logic        sel_wr;
  logic        sel_strobe;

  // Only a high-to-low transition of nWE between requests produces a strobe;
  // a repeated request with nWE still low is serviced as a read.
  assign wr_edge   = ~core_we_n & last_we_n;
  assign req_valid = pend_valid | core_req;
  assign take_core = (state == IDLE) && req_valid;

  // A pending request is older than a live one, so it is serviced first.
  assign sel_addr = pend_valid ? pend_addr : core_addr;
  assign sel_din  = pend_valid ? pend_din  : core_din;
  assign sel_wr   = pend_valid ? pend_wr   : wr_edge;

  // Store the live request unless IDLE is consuming it directly this cycle.
  assign capture = core_req && !((state == IDLE) && !pend_valid);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_din   <= '0;
      pend_wr    <= 1'b0;
      last_we_n  <= 1'b1;
    end else begin
      if (core_req) begin
        last_we_n <= core_we_n;
      end
      if (capture) begin
        pend_valid <= 1'b1;
        pend_addr  <= core_addr;
        pend_din   <= core_din;
        pend_wr    <= wr_edge;
      end else if (take_core && pend_valid) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // ROM write protection
  // --------------------------------------------------------------------------
`ifdef BBC_MEM_ARB_WRITE_PROTECT_EN
  logic sel_rom_wr;
  logic rom_wr_err_reg;

  assign sel_rom_wr = sel_wr & ~sel_addr[18];
  assign sel_strobe = sel_wr &  sel_addr[18];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_wr_err_reg <= 1'b0;
    end else if (take_core && sel_rom_wr) begin
      rom_wr_err_reg <= 1'b1;
    end
  end

  assign rom_wr_err = rom_wr_err_reg;
`else
  assign sel_strobe = sel_wr;
  assign rom_wr_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Loader FIFO: {region, addr[17:0], data[7:0]}
  // --------------------------------------------------------------------------
  logic [26:0]   fifo_mem [LOAD_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          idx_rom;
  logic          idx_ram;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [26:0]   push_word;
  logic [26:0]   pop_word;

  assign idx_rom    = (ioctl_index == LOAD_IDX_ROM);
  assign idx_ram    = (ioctl_index == LOAD_IDX_RAM);
  assign push       = ioctl_download && ioctl_wr && (idx_rom || idx_ram) && (count != DEPTH_C);
  assign push_word  = {idx_ram, ioctl_addr, ioctl_dout};
  assign fifo_empty = (count == '0);
  // Loader only gets the memory when no core request is waiting.
  assign pop        = (state == IDLE) && !req_valid && !fifo_empty;
  assign pop_word   = fifo_mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_word;
    end
  end

  // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ioctl_wait <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count      <= count_next;
      ioctl_wait <= (count_next >= WAIT_C);
    end
  end

  // --------------------------------------------------------------------------
  // Memory sequencer
  // --------------------------------------------------------------------------
  logic cur_wr;  // current core access issued a write strobe

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_wren  <= 1'b0;
      core_dout <= 8'h00;
      core_rdy  <= 1'b0;
      cur_wr    <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      core_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= sel_addr;
            mem_din  <= sel_din;
            mem_wren <= sel_strobe;
            cur_wr   <= sel_strobe;
            state    <= CORE_A;
          end else if (!fifo_empty) begin
            mem_addr <= pop_word[26:8];
            mem_din  <= pop_word[7:0];
            mem_wren <= 1'b1;
            state    <= LOAD_WR;
          end
        end
        CORE_A: begin
          // Memory samples mem_addr at the end of this cycle.
          state <= CORE_D;
        end
        CORE_D: begin
          if (!cur_wr) begin
            core_dout <= mem_q;
          end
          core_rdy <= 1'b1;
          state    <= IDLE;
        end
        LOAD_WR: begin
          // Always return through IDLE so strobes are never back-to-back.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bbc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bbc_mem_arbiter
//
// Directed bench for bbc_mem_arbiter with a behavioural single-port memory
// (registered read, one-cycle read latency) attached to the mem_* port.
// Honours BBC_MEM_ARB_WRITE_PROTECT_EN for the ROM-write step.
// ----------------------------------------------------------------------------
module tb_bbc_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        core_req;
  logic [18:0] core_addr;
  logic        core_we_n;
  logic [7:0]  core_din;
  logic [7:0]  core_dout;
  logic        core_rdy;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [17:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [18:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_wren;
  logic [7:0]  mem_q = 8'h00;
  logic        rom_wr_err;

  always #5 clk_sys = ~clk_sys;

  bbc_mem_arbiter dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .core_req       (core_req),
    .core_addr      (core_addr),
    .core_we_n      (core_we_n),
    .core_din       (core_din),
    .core_dout      (core_dout),
    .core_rdy       (core_rdy),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_wren       (mem_wren),
    .mem_q          (mem_q),
    .rom_wr_err     (rom_wr_err)
  );

  // --------------------------------------------------------------------------
  // Memory model and write log
  // --------------------------------------------------------------------------
  logic [7:0]  mem_arr [0:524287];
  logic        preload_en = 1'b0;
  logic [18:0] preload_addr = '0;
  logic [7:0]  preload_data = '0;
  int          wren_count = 0;
  logic [18:0] log_addr [0:255];
  logic [7:0]  log_data [0:255];
  logic        prev_wren = 1'b0;
  logic        wren_double = 1'b0;

  always @(posedge clk_sys) begin
    mem_q <= mem_arr[mem_addr];
    if (preload_en) mem_arr[preload_addr] <= preload_data;
    if (mem_wren) begin
      mem_arr[mem_addr]        <= mem_din;
      log_addr[wren_count[7:0]] <= mem_addr;
      log_data[wren_count[7:0]] <= mem_din;
      wren_count               <= wren_count + 1;
    end
    prev_wren <= mem_wren;
    if (mem_wren && prev_wren) wren_double <= 1'b1;
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic preload(input logic [18:0] a, input logic [7:0] d);
    preload_addr = a;
    preload_data = d;
    preload_en   = 1'b1;
    step();
    preload_en   = 1'b0;
  endtask

  // Issue one core request and wait (bounded) for core_rdy; lat counts
  // cycles from the request cycle to the cycle core_rdy is seen.
  task automatic do_core(input logic [18:0] a, input logic we_n, input logic [7:0] d,
                         output int lat);
    core_addr = a;
    core_we_n = we_n;
    core_din  = d;
    core_req  = 1'b1;
    step();
    core_req  = 1'b0;
    lat = 1;
    while (!core_rdy && lat < 8) begin
      step();
      lat++;
    end
    $display("core %s addr=0x%05h din=0x%02h dout=0x%02h lat=%0d",
             we_n ? "rd" : "wr", a, d, core_dout, lat);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int lat;
    int w0;
    int i;
    int cyc;
    int nreq;
    int next_req;
    int rdy_cnt;
    logic saw_wait;
    logic saw_lat4;
    int req_cyc_q[$];
    logic [7:0] exp_q[$];

    reset_n        = 1'b0;
    core_req       = 1'b0;
    core_addr      = '0;
    core_we_n      = 1'b1;
    core_din       = '0;
    ioctl_download = 1'b0;
    ioctl_index    = '0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;

    // Preload while reset is held.
    step();
    preload(19'h40123, 8'hA5);
    preload(19'h40020, 8'h11);
    preload(19'h40100, 8'h22);
    for (int k = 0; k < 12; k++) preload(19'h00200 + 19'(k), 8'(k) ^ 8'h5A);

    // ---- reset state ----
    chk("rst_core_dout", {24'h0, core_dout}, 32'h00);
    chk("rst_core_rdy", {31'h0, core_rdy}, 32'h0);
    chk("rst_ioctl_wait", {31'h0, ioctl_wait}, 32'h0);
    chk("rst_mem_addr", {13'h0, mem_addr}, 32'h0);
    chk("rst_mem_din", {24'h0, mem_din}, 32'h0);
    chk("rst_mem_wren", {31'h0, mem_wren}, 32'h0);
    chk("rst_rom_wr_err", {31'h0, rom_wr_err}, 32'h0);
    reset_n = 1'b1;
    step();
    step();
    $display("reset released");

    // ---- core read 0x40123 ----
    w0 = wren_count;
    core_addr = 19'h40123;
    core_we_n = 1'b1;
    core_req  = 1'b1;
    step();
    core_req = 1'b0;
    chk("rd_mem_addr_n1", {13'h0, mem_addr}, 32'h40123);
    chk("rd_rdy_n1", {31'h0, core_rdy}, 32'h0);
    step();
    chk("rd_rdy_n2", {31'h0, core_rdy}, 32'h0);
    step();
    chk("rd_rdy_n3", {31'h0, core_rdy}, 32'h1);
    chk("rd_dout_n3", {24'h0, core_dout}, 32'hA5);
    chk("rd_no_wren", wren_count, w0);
    $display("core rd addr=0x40123 dout=0x%02h", core_dout);

    // ---- core write 0x40010 = 0x3C, then repeat with nWE still low ----
    w0 = wren_count;
    core_addr = 19'h40010;
    core_we_n = 1'b0;
    core_din  = 8'h3C;
    core_req  = 1'b1;
    step();
    core_req = 1'b0;
    chk("wr_strobe_n1", {31'h0, mem_wren}, 32'h1);
    chk("wr_din_n1", {24'h0, mem_din}, 32'h3C);
    chk("wr_addr_n1", {13'h0, mem_addr}, 32'h40010);
    step();
    chk("wr_strobe_n2", {31'h0, mem_wren}, 32'h0);
    step();
    chk("wr_rdy_n3", {31'h0, core_rdy}, 32'h1);
    chk("wr_dout_kept", {24'h0, core_dout}, 32'hA5);
    $display("core wr addr=0x40010 din=0x3C");
    do_core(19'h40010, 1'b0, 8'h77, lat);
    core_we_n = 1'b1;
    chk("wr2_latency", lat, 3);
    chk("wr2_single_strobe", wren_count, w0 + 1);
    chk("wr2_mem_data", {24'h0, mem_arr[19'h40010]}, 32'h3C);
    chk("wr2_as_read_dout", {24'h0, core_dout}, 32'h3C);

    // ---- loader bytes with an unrouted index are dropped ----
    w0 = wren_count;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd2;
    for (int k = 0; k < 4; k++) begin
      ioctl_addr = 18'(k);
      ioctl_dout = 8'hF0;
      ioctl_wr   = 1'b1;
      step();
    end
    ioctl_wr = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("bad_idx_no_write", wren_count, w0);
    chk("bad_idx_no_wait", {31'h0, ioctl_wait}, 32'h0);
    $display("loader idx=2 bytes=4 writes=%0d", wren_count - w0);

    // ---- loader burst idx0, addrs 0..15, core idle ----
    w0 = wren_count;
    ioctl_index = 8'd0;
    i = 0;
    cyc = 0;
    saw_wait = 1'b0;
    while (cyc < 300 && (i < 16 || wren_count < w0 + 16)) begin
      ioctl_wr = 1'b0;
      if (ioctl_wait) saw_wait = 1'b1;
      if (i < 16 && !ioctl_wait) begin
        ioctl_addr = 18'(i);
        ioctl_dout = 8'h10 + 8'(i);
        ioctl_wr   = 1'b1;
        i++;
      end
      step();
      cyc++;
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    step();
    step();
    chk("ld0_write_count", wren_count, w0 + 16);
    chk("ld0_wait_seen", {31'h0, saw_wait}, 32'h1);
    chk("ld0_wait_clear", {31'h0, ioctl_wait}, 32'h0);
    for (int k = 0; k < 16; k++) begin
      chk("ld0_addr", {13'h0, log_addr[(w0 + k) & 255]}, 32'(k));
      chk("ld0_data", {24'h0, log_data[(w0 + k) & 255]}, 32'h10 + 32'(k));
    end
    $display("loader idx=0 bytes=16 writes=%0d cycles=%0d", wren_count - w0, cyc);

    // ---- loader burst idx1 interleaved with core reads ----
    w0 = wren_count;
    ioctl_download = 1'b1;
    ioctl_index = 8'd1;
    i = 0;
    cyc = 0;
    nreq = 0;
    next_req = 0;
    rdy_cnt = 0;
    saw_lat4 = 1'b0;
    while (cyc < 600 && (i < 16 || wren_count < w0 + 16 || nreq < 12 || req_cyc_q.size() != 0)) begin
      if (core_rdy) begin
        rdy_cnt++;
        if (req_cyc_q.size() == 0) begin
          chk("mix_rdy_unexpected", {31'h0, core_rdy}, 32'h0);
        end else begin
          lat = cyc - req_cyc_q.pop_front();
          if (lat == 4) saw_lat4 = 1'b1;
          chk("mix_latency_3_or_4", {31'h0, (lat >= 3 && lat <= 4)}, 32'h1);
          chk("mix_dout", {24'h0, core_dout}, {24'h0, exp_q.pop_front()});
        end
      end
      core_req = 1'b0;
      ioctl_wr = 1'b0;
      if (cyc == next_req && nreq < 12) begin
        core_addr = 19'h00200 + 19'(nreq);
        core_we_n = 1'b1;
        core_req  = 1'b1;
        req_cyc_q.push_back(cyc);
        exp_q.push_back(8'(nreq) ^ 8'h5A);
        next_req = cyc + 3 + (nreq % 2);
        nreq++;
      end
      if (i < 16 && !ioctl_wait) begin
        ioctl_addr = 18'(i);
        ioctl_dout = 8'h80 + 8'(i);
        ioctl_wr   = 1'b1;
        i++;
      end
      step();
      cyc++;
    end
    core_req = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    chk("mix_rdy_count", rdy_cnt, 12);
    chk("mix_lat4_seen", {31'h0, saw_lat4}, 32'h1);
    chk("mix_write_count", wren_count, w0 + 16);
    for (int k = 0; k < 16; k++) begin
      chk("mix_addr", {13'h0, log_addr[(w0 + k) & 255]}, 32'h40000 + 32'(k));
      chk("mix_data", {24'h0, log_data[(w0 + k) & 255]}, 32'h80 + 32'(k));
    end
    $display("loader idx=1 bytes=16 writes=%0d core_reads=%0d cycles=%0d",
             wren_count - w0, rdy_cnt, cyc);

    // ---- core write into the ROM region ----
    w0 = wren_count;
    do_core(19'h04000, 1'b0, 8'h99, lat);
    core_we_n = 1'b1;
    chk("rom_wr_latency", lat, 3);
`ifdef BBC_MEM_ARB_WRITE_PROTECT_EN
    chk("rom_wr_blocked", wren_count, w0);
    chk("rom_wr_err_set", {31'h0, rom_wr_err}, 32'h1);
`else
    chk("rom_wr_passed", wren_count, w0 + 1);
    chk("rom_wr_addr", {13'h0, log_addr[w0 & 255]}, 32'h04000);
    chk("rom_wr_err_low", {31'h0, rom_wr_err}, 32'h0);
`endif

    // ---- reset during CORE_A of a write, with a loader byte queued ----
    do_core(19'h40123, 1'b1, 8'h00, lat);
    chk("rearm_dout", {24'h0, core_dout}, 32'hA5);
    w0 = wren_count;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    ioctl_addr     = 18'h00100;
    ioctl_dout     = 8'hEE;
    ioctl_wr       = 1'b1;
    core_addr      = 19'h40020;
    core_we_n      = 1'b0;
    core_din       = 8'h55;
    core_req       = 1'b1;
    step();
    core_req       = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    core_we_n      = 1'b1;
    chk("abort_in_core_a", {31'h0, mem_wren}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("abort_wren_cleared", {31'h0, mem_wren}, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("abort_no_write", wren_count, w0);
    chk("abort_core_mem", {24'h0, mem_arr[19'h40020]}, 32'h11);
    chk("abort_load_mem", {24'h0, mem_arr[19'h40100]}, 32'h22);
    chk("abort_ioctl_wait", {31'h0, ioctl_wait}, 32'h0);
    chk("abort_core_dout", {24'h0, core_dout}, 32'h00);
    chk("abort_mem_addr", {13'h0, mem_addr}, 32'h0);
    chk("abort_mem_din", {24'h0, mem_din}, 32'h0);
    chk("abort_rom_wr_err", {31'h0, rom_wr_err}, 32'h0);
    $display("reset abort writes=%0d", wren_count - w0);

    chk("no_back_to_back_wren", {31'h0, wren_double}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
